transaction_sequencer: RTL and testbench

- Parametrised step sequencer driving the transaction pipeline: verify, hash, hash store, memory store.
- Replaces the fixed 3-step transaction controller and the hand-written done multiplexer at top level.
- Selects the done line of the active step internally, issues a one-cycle start pulse per step, and enforces a per-step timeout with bounded retry.
- Reports finish, abort and failure to the main controller.

---
 rtl/transaction_sequencer_if.sv | 39 +++
 rtl/transaction_sequencer.sv | 118 +++++++++++
 tb/tb_transaction_sequencer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/transaction_sequencer_if.sv
// transaction_sequencer_if: control/status bundle between the main controller and the step sequencer.
// Carries skip_mask only when STEP_SKIP_EN is defined.
interface transaction_sequencer_if #(
    parameter int NUM_STEPS = 4,
    parameter int STEP_W    = 3,
    parameter int TIMEOUT_W = 16
);
    logic                 start;
    logic                 abort;
    logic [NUM_STEPS-1:0] done_in;
    logic [TIMEOUT_W-1:0] timeout_limit;
`ifdef STEP_SKIP_EN
    logic [NUM_STEPS-1:0] skip_mask;
`endif
    logic [STEP_W-1:0]    step;
    logic                 step_start;
    logic                 busy;
    logic                 finished;
    logic                 aborted;
    logic                 error;
    logic [STEP_W-1:0]    error_step;
    logic [1:0]           retry_count;

    modport master (
`ifdef STEP_SKIP_EN
        output skip_mask,
`endif
        output start, abort, done_in, timeout_limit,
        input  step, step_start, busy, finished, aborted, error, error_step, retry_count
    );

    modport slave (
`ifdef STEP_SKIP_EN
        input  skip_mask,
`endif
        input  start, abort, done_in, timeout_limit,
        output step, step_start, busy, finished, aborted, error, error_step, retry_count
    );
endinterface

// File: rtl/transaction_sequencer.sv
// transaction_sequencer: parametrised step sequencer with per-step timeout and bounded retry.
// Optional STEP_SKIP_EN adds skip_mask so advances jump straight to the next unskipped step.
module transaction_sequencer #(
    parameter int NUM_STEPS = 4,
    parameter int STEP_W    = 3,
    parameter int TIMEOUT_W = 16,
    parameter int MAX_RETRY = 2
) (
    input logic clock,
    input logic reset,
    transaction_sequencer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ISSUE, RUN, FINISH, FAIL} state_t;

    state_t               r_state, w_next;
    logic [STEP_W-1:0]    r_step, w_step, r_err_step, w_err_step, w_adv, w_first;
    logic [TIMEOUT_W-1:0] r_timer;
    logic [1:0]           r_retry, w_retry;
    logic                 r_error, w_error, r_aborted, w_aborted;
    logic [NUM_STEPS-1:0] w_skip, w_sel;
    logic                 w_done, w_timeout, w_kill;

`ifdef STEP_SKIP_EN
    assign w_skip = bus.skip_mask;
`else
    assign w_skip = '0;
`endif

    // Only the active step's done line matters; step 0 shifts the select out of range.
    assign w_sel     = NUM_STEPS'(1) << (r_step - STEP_W'(1));
    assign w_done    = |(bus.done_in & w_sel);
    assign w_timeout = (bus.timeout_limit != '0) && (r_timer == bus.timeout_limit - TIMEOUT_W'(1));
    assign w_kill    = bus.abort && (r_state == ISSUE || r_state == RUN);

    // Lowest unskipped step above the current one (w_adv) and above zero (w_first); 0 means none.
    always_comb begin
        w_adv   = '0;
        w_first = '0;
        for (int i = NUM_STEPS - 1; i >= 0; i--) begin
            if (!w_skip[i] && i >= int'(r_step)) w_adv = STEP_W'(i + 1);
            if (!w_skip[i]) w_first = STEP_W'(i + 1);
        end
    end

    always_comb begin
        w_next     = r_state;
        w_step     = r_step;
        w_retry    = r_retry;
        w_error    = r_error;
        w_err_step = r_err_step;
        w_aborted  = 1'b0;
        case (r_state)
            IDLE, FAIL: if (bus.start) begin
                w_step     = w_first;
                w_retry    = '0;
                w_error    = 1'b0;
                w_err_step = '0;
                w_next     = (w_first == '0) ? FINISH : ISSUE;
            end
            ISSUE: w_next = RUN;
            RUN: if (w_done) begin
                w_step  = w_adv;
                w_retry = '0;
                w_next  = (w_adv == '0) ? FINISH : ISSUE;
            end else if (w_timeout) begin
                if (int'(r_retry) < MAX_RETRY) begin
                    w_retry = (r_retry == 2'd3) ? r_retry : r_retry + 2'd1;
                    w_next  = ISSUE;
                end else begin
                    w_error    = 1'b1;
                    w_err_step = r_step;
                    w_step     = '0;
                    w_next     = FAIL;
                end
            end
            FINISH: w_next = IDLE;
            default: w_next = IDLE;
        endcase
        // Abort outranks done, timeout and start; in FAIL it only clears the error.
        if (w_kill || (bus.abort && r_state == FAIL)) begin
            w_next     = IDLE;
            w_step     = '0;
            w_retry    = '0;
            w_error    = 1'b0;
            w_err_step = '0;
            w_aborted  = w_kill;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_step     <= '0;
            r_timer    <= '0;
            r_retry    <= '0;
            r_error    <= 1'b0;
            r_err_step <= '0;
            r_aborted  <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_step     <= w_step;
            r_timer    <= (w_next == RUN) ? r_timer + TIMEOUT_W'(!(&r_timer)) : '0;
            r_retry    <= w_retry;
            r_error    <= w_error;
            r_err_step <= w_err_step;
            r_aborted  <= w_aborted;
        end
    end

    assign bus.step        = r_step;
    assign bus.step_start  = (r_state == ISSUE);
    assign bus.busy        = (r_state == ISSUE) || (r_state == RUN);
    assign bus.finished    = (r_state == FINISH);
    assign bus.aborted     = r_aborted;
    assign bus.error       = r_error;
    assign bus.error_step  = r_err_step;
    assign bus.retry_count = r_retry;
endmodule

// File: tb/tb_transaction_sequencer.sv
// tb_transaction_sequencer: table-driven and randomized checks of transaction_sequencer.
// Each table row holds one cycle's inputs plus the outputs expected during that cycle.
module tb_transaction_sequencer;
    localparam int N = 4, SW = 3, TW = 16, MR = 2;

    typedef struct {
        logic start, abort;
        logic [N-1:0] done;
        logic [TW-1:0] tl;
        logic [SW-1:0] step;
        logic ss, busy, fin, abt, err;
        logic [SW-1:0] estep;
        logic [1:0] retry;
    } vec_t;

    logic clk = 1'b0, rst = 1'b1;
    int checks = 0, failures = 0;
    vec_t tbl[$];
    int m_err = 0, m_estep = 0, m_retry = 0;

    transaction_sequencer_if #(.NUM_STEPS(N), .STEP_W(SW), .TIMEOUT_W(TW)) bus();
    transaction_sequencer #(.NUM_STEPS(N), .STEP_W(SW), .TIMEOUT_W(TW), .MAX_RETRY(MR)) dut (
        .clock(clk), .reset(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    function automatic vec_t mk(input int s, a, input logic [N-1:0] d, input int l, st, ss, b, f, ab, e, es, r);
        vec_t v;
        v.start = 1'(s); v.abort = 1'(a); v.done = d; v.tl = TW'(l);
        v.step = SW'(st); v.ss = 1'(ss); v.busy = 1'(b); v.fin = 1'(f); v.abt = 1'(ab);
        v.err = 1'(e); v.estep = SW'(es); v.retry = 2'(r);
        return v;
    endfunction

    task automatic p(input int s, a, input logic [N-1:0] d, input int l, st, ss, b, f, ab, e, es, r);
        tbl.push_back(mk(s, a, d, l, st, ss, b, f, ab, e, es, r));
    endtask

    function automatic logic [12:0] pk(input vec_t v);
        return {v.step, v.ss, v.busy, v.fin, v.abt, v.err, v.estep, v.retry};
    endfunction

    function automatic logic [12:0] act();
        return {bus.step, bus.step_start, bus.busy, bus.finished, bus.aborted, bus.error, bus.error_step, bus.retry_count};
    endfunction

    function automatic string fmt(input logic [12:0] v);
        return $sformatf("step=%0d start=%b busy=%b fin=%b abt=%b err=%b estep=%0d retry=%0d",
                         v[12:10], v[9], v[8], v[7], v[6], v[5], v[4:2], v[1:0]);
    endfunction

    task automatic check(input string name, input logic [12:0] got, input logic [12:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got {%s} expected {%s}", name, fmt(got), fmt(exp));
        end
    endtask

    task automatic run_tbl(input string name);
        foreach (tbl[i]) begin
            check($sformatf("%s[%0d]", name, i), act(), pk(tbl[i]));
            bus.start = tbl[i].start;
            bus.abort = tbl[i].abort;
            bus.done_in = tbl[i].done;
            bus.timeout_limit = tbl[i].tl;
            @(posedge clk);
            #1;
        end
        tbl.delete();
    endtask

    function automatic int rb();
        return int'($urandom_range(0, 1));
    endfunction

    function automatic logic [N-1:0] rn();
        return N'($urandom);
    endfunction

    // Reference: each attempt is ISSUE then RUN cycles until done or (limit-1) cycles pass.
    task automatic gen_rand();
        int l, d;
        bit ok;
        logic [N-1:0] nz, bk;
        l = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(2, 7));
        p(1, 0, rn(), l, 0, 0, 0, 0, 0, m_err, m_estep, m_retry);
        m_err = 0; m_estep = 0; m_retry = 0;
        for (int k = 1; k <= N; k++) begin
            bk = N'(1) << (k - 1);
            for (int r = 0; r <= MR; r++) begin
                ok = (l == 0) || ($urandom_range(0, 2) != 0);
                d = ok ? int'($urandom_range(1, (l == 0) ? 5 : l - 1)) : l - 1;
                p(rb(), 0, rn(), l, k, 1, 1, 0, 0, 0, 0, r);
                for (int c = 1; c <= d; c++) begin
                    nz = rn();
                    if ($urandom_range(0, 40) == 0) begin
                        p(rb(), 1, nz, l, k, 0, 1, 0, 0, 0, 0, r);
                        p(0, 0, rn(), l, 0, 0, 0, 0, 1, 0, 0, 0);
                        return;
                    end
                    p(rb(), 0, (ok && c == d) ? (nz | bk) : (nz & ~bk), l, k, 0, 1, 0, 0, 0, 0, r);
                end
                if (ok) break;
                if (r == MR) begin
                    p(0, 0, rn(), l, 0, 0, 0, 0, 0, 1, k, r);
                    p(0, 0, rn(), l, 0, 0, 0, 0, 0, 1, k, r);
                    m_err = 1; m_estep = k; m_retry = r;
                    return;
                end
            end
        end
        p(0, 0, rn(), l, 0, 0, 0, 1, 0, 0, 0, 0);
    endtask

    initial begin
        bus.start = 1'b0; bus.abort = 1'b0; bus.done_in = '0; bus.timeout_limit = '0;
`ifdef STEP_SKIP_EN
        bus.skip_mask = '0;
`endif
        #12;
        check("reset", act(), 13'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;

        // nominal: finished 9 cycles after start
        p(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= N; k++) begin
            p(0, 0, 0, 0, k, 1, 1, 0, 0, 0, 0, 0);
            p(0, 0, N'(1) << (k - 1), 0, k, 0, 1, 0, 0, 0, 0, 0);
        end
        p(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        p(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        run_tbl("nominal");

        // wrong-step done bits, then abort together with done and start
        p(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        p(0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0);
        p(0, 0, 4'b0001, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        p(0, 0, 0, 0, 2, 1, 1, 0, 0, 0, 0, 0);
        p(0, 0, 4'b0101, 0, 2, 0, 1, 0, 0, 0, 0, 0);
        p(0, 0, 4'b1101, 0, 2, 0, 1, 0, 0, 0, 0, 0);
        p(0, 0, 4'b0010, 0, 2, 0, 1, 0, 0, 0, 0, 0);
        p(0, 0, 0, 0, 3, 1, 1, 0, 0, 0, 0, 0);
        p(1, 1, 4'b0100, 0, 3, 0, 1, 0, 0, 0, 0, 0);
        p(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        p(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        run_tbl("wrongstep");

        // timeout=5: step 3 retried twice then fails; recovery with done on the timeout cycle
        p(1, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0);
        p(0, 0, 0, 5, 1, 1, 1, 0, 0, 0, 0, 0);
        p(0, 0, 4'b0001, 5, 1, 0, 1, 0, 0, 0, 0, 0);
        p(0, 0, 0, 5, 2, 1, 1, 0, 0, 0, 0, 0);
        p(0, 0, 4'b0010, 5, 2, 0, 1, 0, 0, 0, 0, 0);
        for (int r = 0; r <= MR; r++) begin
            p(0, 0, 0, 5, 3, 1, 1, 0, 0, 0, 0, r);
            repeat (4) p(0, 0, 4'b1011, 5, 3, 0, 1, 0, 0, 0, 0, r);
        end
        p(0, 0, 0, 5, 0, 0, 0, 0, 0, 1, 3, 2);
        p(1, 0, 0, 5, 0, 0, 0, 0, 0, 1, 3, 2);
        p(0, 0, 0, 5, 1, 1, 1, 0, 0, 0, 0, 0);
        repeat (3) p(0, 0, 0, 5, 1, 0, 1, 0, 0, 0, 0, 0);
        p(0, 0, 4'b0001, 5, 1, 0, 1, 0, 0, 0, 0, 0);
        p(0, 0, 0, 5, 2, 1, 1, 0, 0, 0, 0, 0);
        repeat (4) p(0, 0, 0, 5, 2, 0, 1, 0, 0, 0, 0, 0);
        p(0, 0, 0, 5, 2, 1, 1, 0, 0, 0, 0, 1);
        p(0, 1, 4'b0010, 5, 2, 0, 1, 0, 0, 0, 0, 1);
        p(0, 0, 0, 2, 0, 0, 0, 0, 1, 0, 0, 0);
        // timeout=2: fail on step 1, then abort+start in FAIL clears quietly
        p(1, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int r = 0; r <= MR; r++) begin
            p(0, 0, 0, 2, 1, 1, 1, 0, 0, 0, 0, r);
            p(0, 0, 0, 2, 1, 0, 1, 0, 0, 0, 0, r);
        end
        p(0, 0, 0, 2, 0, 0, 0, 0, 0, 1, 1, 2);
        p(1, 1, 0, 2, 0, 0, 0, 0, 0, 1, 1, 2);
        p(0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0);
        p(0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0);
        run_tbl("timeout");

        for (int s = 0; s < 40; s++) begin
            gen_rand();
            run_tbl($sformatf("rand%0d", s));
        end

        // asynchronous reset in the middle of step 2
        p(1, 0, 0, 0, m_err == 0 ? 0 : 0, 0, 0, 0, 0, m_err, m_estep, m_retry);
        p(0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0);
        p(0, 0, 4'b0001, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        p(0, 0, 0, 0, 2, 1, 1, 0, 0, 0, 0, 0);
        p(0, 0, 0, 0, 2, 0, 1, 0, 0, 0, 0, 0);
        run_tbl("prereset");
        check("step2_hold", act(), pk(mk(0, 0, 0, 0, 2, 0, 1, 0, 0, 0, 0, 0)));
        #2 rst = 1'b1;
        #1 check("async_reset", act(), 13'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1 check("post_reset", act(), 13'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
